// File: rtl/uart_byte_receiver.sv
// 8N1 serial receiver: 2-flop synchroniser, oversampled start qualification,
// 3-sample majority vote per bit, framing-error strobe with break recovery.
module uart_byte_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int TICK_DIV = (CLK_FREQ_HZ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_V2   = SW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   samp_q, samp_d, samp_nxt;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      vote_q, vote_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            rx_s, tick, maj;

  assign rx_s     = sync_q[1];
  assign samp_nxt = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
  // Third sample is the live synchronised line; the first two were latched earlier.
  assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      vote_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      vote_q  <= vote_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    vote_d  = vote_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    tick    = 1'b0;

    if (state_q != IDLE) begin
      tick   = (tick_q == TICK_LAST);
      tick_d = tick ? '0 : tick_q + 1'b1;
    end

    // In BRK the sample counter instead counts consecutive high ticks.
    if (tick && state_q != BRK) begin
      samp_d = samp_nxt;
      if (samp_q == SAMP_V0) vote_d[0] = rx_s;
      if (samp_q == SAMP_V1) vote_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick && samp_q == SAMP_V2 && maj) begin
          state_d = IDLE;
        end else if (tick && samp_q == SAMP_LAST) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick && samp_q == SAMP_V2) shift_d = {maj, shift_q[7:1]};
        if (tick && samp_q == SAMP_LAST) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at the stop-bit vote so a following start edge is never missed.
        if (tick && samp_q == SAMP_V2) begin
          if (maj) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BRK;
            samp_d  = '0;
          end
        end
      end
      BRK: begin
        if (tick) begin
          if (!rx_s) samp_d = '0;
          else if (samp_q == SAMP_LAST) state_d = IDLE;
          else samp_d = samp_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      tick_d = '0;
      samp_d = '0;
    end
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver at 16 clocks per bit: directed corner cases,
// a vector table, and randomized frames scored against a frame-level model.
module tb_uart_byte_receiver;
  localparam int OS = 16;
  localparam int FRAME = 10 * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid, framing_error, busy;

  uart_byte_receiver #(.CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data),
    .data_valid(data_valid), .framing_error(framing_error), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, n_dv = 0, n_fe = 0, both_hi = 0;
  int dv_cyc = 0, start_cyc = 0, fall_cyc = 0, last_gap = 0;
  logic prev_busy = 1'b0;
  logic [7:0] got_q[$];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         jit;
    logic       glitch;
    logic [7:0] exp_data;
    int         exp_dv;
    int         exp_fe;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // Drives one frame, one rx value per clock; inner bit edges optionally jittered,
  // or every bit given a one-clock inversion at its centre.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int jit,
                            input logic glitch, input int len);
    logic       wave[FRAME];
    int         e[11];
    logic [9:0] bits;
    bits  = {stop, b, 1'b0};
    e[0]  = 0;
    e[10] = FRAME;
    for (int k = 1; k < 10; k++)
      e[k] = OS * k + ((jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0);
    for (int k = 0; k < 10; k++)
      for (int t = e[k]; t < e[k+1]; t++) wave[t] = bits[k];
    if (glitch)
      for (int k = 0; k < 10; k++) wave[OS * k + 9] = ~wave[OS * k + 9];
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      rx = wave[t];
      if (t == 0) start_cyc = cyc + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (data_valid) begin
        n_dv++;
        dv_cyc = cyc;
        got_q.push_back(data);
      end
      if (framing_error) n_fe++;
      if (data_valid && framing_error) both_hi++;
      if (busy && !prev_busy) last_gap = cyc - fall_cyc;
      if (!busy && prev_busy) fall_cyc = cyc;
      prev_busy = busy;
    end
  end

  initial begin
    int d0, f0, exp_fe;
    logic [7:0] exp_last, b;
    logic good;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'hA5, 1'b1, 0, 1'b0, 8'hA5, 1, 0};
    vecs[1] = '{8'hC3, 1'b1, 3, 1'b0, 8'hC3, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 0, 1'b0, 8'h00, 1, 0};
    vecs[3] = '{8'hC3, 1'b1, 0, 1'b1, 8'hC3, 1, 0};
    vecs[4] = '{8'h55, 1'b0, 0, 1'b0, 8'hC3, 0, 1};
    vecs[5] = '{8'h33, 1'b1, 0, 1'b0, 8'h33, 1, 0};
    vecs[6] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_fe", int'(framing_error), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    hold(1'b1, 10);

    // single frame and its latency from the first clock seeing the start edge
    d0 = n_dv; f0 = n_fe;
    send_frame(8'h2C, 1'b1, 0, 1'b0, FRAME);
    hold(1'b1, 20);
    chk("one_dv", n_dv - d0, 1);
    chk("one_data", int'(data), 'h2C);
    chk("one_fe", n_fe - f0, 0);
    chk_rng("one_latency", dv_cyc - start_cyc, 154, 157);

    // back-to-back "12," with no idle gap
    d0 = n_dv;
    got_q.delete();
    send_frame(8'h31, 1'b1, 0, 1'b0, FRAME);
    send_frame(8'h32, 1'b1, 0, 1'b0, FRAME);
    chk_rng("b2b_gap1", last_gap, 1, OS / 2);
    send_frame(8'h2C, 1'b1, 0, 1'b0, FRAME);
    chk_rng("b2b_gap2", last_gap, 1, OS / 2);
    hold(1'b1, 20);
    chk("b2b_count", n_dv - d0, 3);
    chk("b2b_byte0", (got_q.size() > 0) ? int'(got_q[0]) : -1, 'h31);
    chk("b2b_byte1", (got_q.size() > 1) ? int'(got_q[1]) : -1, 'h32);
    chk("b2b_byte2", (got_q.size() > 2) ? int'(got_q[2]) : -1, 'h2C);

    // 3-clock low glitch must be rejected at the start-bit vote
    d0 = n_dv; f0 = n_fe;
    hold(1'b0, 3);
    hold(1'b1, 16);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_dv", n_dv - d0, 0);
    chk("glitch_fe", n_fe - f0, 0);
    send_frame(8'hA5, 1'b1, 0, 1'b0, FRAME);
    hold(1'b1, 20);
    chk("glitch_next_dv", n_dv - d0, 1);
    chk("glitch_next_data", int'(data), 'hA5);

    // vector table; a bad stop bit is followed by a 40-bit-time break
    foreach (vecs[i]) begin
      d0 = n_dv; f0 = n_fe;
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].jit, vecs[i].glitch, FRAME);
      if (!vecs[i].stop) hold(1'b0, 40 * OS);
      hold(1'b1, 40);
      chk($sformatf("vec%0d_dv", i), n_dv - d0, vecs[i].exp_dv);
      chk($sformatf("vec%0d_fe", i), n_fe - f0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
    end

    // reset during data bit 4 of 0xFF
    d0 = n_dv; f0 = n_fe;
    send_frame(8'hFF, 1'b1, 0, 1'b0, 88);
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("midrst_data", int'(data), 0);
    chk("midrst_dv", int'(data_valid), 0);
    chk("midrst_fe", int'(framing_error), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 20);
    chk("midrst_no_dv", n_dv - d0, 0);
    chk("midrst_no_fe", n_fe - f0, 0);
    send_frame(8'h0F, 1'b1, 0, 1'b0, FRAME);
    hold(1'b1, 20);
    chk("midrst_next_dv", n_dv - d0, 1);
    chk("midrst_next_data", int'(data), 'h0F);

    // randomized frames: good frames queue their byte, bad stop bits count one error
    got_q.delete();
    exp_last = 8'h0F;
    exp_fe = 0;
    f0 = n_fe;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(4) != 0);
      send_frame(b, good, int'($urandom_range(2)), 1'b0, FRAME);
      if (good) begin
        exp_q.push_back(b);
        exp_last = b;
        hold(1'b1, int'($urandom_range(20)));
      end else begin
        exp_fe++;
        hold(1'b0, OS * int'($urandom_range(3)));
        hold(1'b1, 24 + int'($urandom_range(10)));
      end
    end
    hold(1'b1, 30);
    chk("rnd_count", got_q.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("rnd_byte%0d", i), (got_q.size() > i) ? int'(got_q[i]) : -1, int'(exp_q[i]));
    chk("rnd_fe", n_fe - f0, exp_fe);
    chk("rnd_data", int'(data), int'(exp_last));

    chk("dv_fe_overlap", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
